// File: rtl/mc_commit_trace_buf.sv
// mc_commit_trace_buf: commit-trace FIFO with drop/overflow/commit accounting.
// Define TRACE_TIMESTAMP_EN to store a per-record cycle timestamp on out_ts.
module mc_commit_trace_buf #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int DEPTH  = 8,
    parameter int TS_W   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_pc,
    input  logic [DATA_W-1:0]        in_instr,
    input  logic [REG_W-1:0]         in_rd,
    input  logic [DATA_W-1:0]        in_wdata,
    input  logic                     in_wen,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_pc,
    output logic [DATA_W-1:0]        out_instr,
    output logic [REG_W-1:0]         out_rd,
    output logic [DATA_W-1:0]        out_wdata,
    output logic                     out_wen,
`ifdef TRACE_TIMESTAMP_EN
    output logic [TS_W-1:0]          out_ts,
`endif
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [15:0]              drop_cnt,
    output logic [31:0]              commit_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TS_W < 1) begin : g_bad_param
        $error("mc_commit_trace_buf: DEPTH must be a power of two >= 2 and TS_W >= 1");
    end

    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [DATA_W-1:0] pc_mem    [DEPTH];
    logic [DATA_W-1:0] instr_mem [DEPTH];
    logic [REG_W-1:0]  rd_mem    [DEPTH];
    logic [DATA_W-1:0] wdata_mem [DEPTH];
    logic              wen_mem   [DEPTH];
    logic              full, pop, push;

    assign full      = count == CW'(DEPTH);
    assign out_valid = count != '0;
    assign pop       = out_valid & out_ready;
    // A full FIFO still accepts a record when the head leaves in the same cycle.
    assign push      = in_valid & (~full | pop);

    assign out_pc    = out_valid ? pc_mem[rd_ptr]    : '0;
    assign out_instr = out_valid ? instr_mem[rd_ptr] : '0;
    assign out_rd    = out_valid ? rd_mem[rd_ptr]    : '0;
    assign out_wdata = out_valid ? wdata_mem[rd_ptr] : '0;
    assign out_wen   = out_valid ? wen_mem[rd_ptr]   : 1'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            drop_cnt   <= '0;
            commit_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
            if (in_valid) commit_cnt <= commit_cnt + 1'b1;
            if (in_valid & ~push) begin
                overflow <= 1'b1;
                if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

    // Storage is deliberately left uncleared; pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push & ~reset) begin
            pc_mem[wr_ptr]    <= in_pc;
            instr_mem[wr_ptr] <= in_instr;
            rd_mem[wr_ptr]    <= in_rd;
            wdata_mem[wr_ptr] <= in_wdata;
            wen_mem[wr_ptr]   <= in_wen;
        end
    end

`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts;
    logic [TS_W-1:0] ts_mem [DEPTH];

    assign out_ts = out_valid ? ts_mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (reset) ts <= '0;
        else ts <= ts + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push & ~reset) ts_mem[wr_ptr] <= ts;
    end
`endif
endmodule
